// File: rtl/fp_normaliser.sv
// Post-addition normaliser for IEEE-754 single precision. It takes a raw 25-bit mantissa sum,
// shifts it one bit per cycle until the hidden bit is set, and truncates the result.
module fp_normaliser (
  input  logic        clk,
  input  logic        rst,
  input  logic        sign,
  input  logic [7:0]  Ex,
  input  logic [24:0] mant,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_e;

  state_e      state_q,  state_d;
  logic        sign_q,   sign_d;
  logic [7:0]  exp_q,    exp_d;
  logic [24:0] mant_q,   mant_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q,    ovf_d;
  logic        unf_q,    unf_d;

  always_comb begin
    // NOTE: every signal gets its hold value first, so no path through the case leaves one unassigned (no latch).
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_d   = mant_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = sign;
          mant_d = mant;
          exp_d  = (Ex == 8'h00) ? 8'h01 : Ex;
          if (Ex == 8'hFF) begin
            // Inf/NaN operands pass straight through without normalising.
            result_d = {sign, 8'hFF, mant[22:0]};
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
            state_d  = DONE;
          end else begin
            state_d  = NORM;
          end
        end
      end

      NORM: begin
        state_d = DONE;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        if (mant_q == 25'd0) begin
          result_d = 32'h0000_0000;
        end else if (mant_q[24] && exp_q == 8'hFE) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
        end else if (mant_q[24]) begin
          result_d = {sign_q, exp_q + 8'd1, mant_q[23:1]};
        end else if (mant_q[23]) begin
          result_d = {sign_q, exp_q, mant_q[22:0]};
        end else if (exp_q <= 8'd1) begin
          result_d = {sign_q, 8'h00, mant_q[22:0]};
          unf_d    = 1'b1;
        end else begin
          mant_d  = mant_q << 1;
          exp_d   = exp_q - 8'd1;
          state_d = NORM;
        end
      end

      DONE: begin
        if (out_ready) begin
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= 8'h00;
      mant_q   <= 25'd0;
      result_q <= 32'h0000_0000;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_q   <= mant_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: doc/fp_normaliser.md
FP_NORMALISER -- requirements
Module: fp_normaliser

Interface
REQ-001 SHALL use a single clock; reset is synchronous and active-high.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-004 SHALL have port sign, input, 1 bit: sign of the raw sum.
REQ-005 SHALL have port Ex, input, 8 bits: common exponent of the aligned operands.
REQ-006 SHALL have port mant, input, 25 bits: raw mantissa sum; bit 24 is carry, bit 23 is hidden-bit position.
REQ-007 SHALL have port in_valid, input, 1 bit: input operands valid.
REQ-008 SHALL have port in_ready, output, 1 bit: block can accept an input.
REQ-009 SHALL have port result, output, 32 bits: IEEE-754 single {sign, exp[7:0], frac[22:0]}.
REQ-010 SHALL have port out_valid, output, 1 bit: result valid.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-012 SHALL have port overflow, output, 1 bit: result saturated to infinity.
REQ-013 SHALL have port underflow, output, 1 bit: result is subnormal, nonzero.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, NORM, DONE.
REQ-015 SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE.
REQ-016 SHALL accept an input on a clk edge with in_valid=1 and in_ready=1, as follows:
- register sign, mant and exponent;
- substitute exponent 1 when Ex=0;
- go to NORM.
REQ-017 SHALL, on acceptance with Ex=0xFF, bypass NORM and go directly to DONE with result={sign,8'hFF,mant[22:0]}, overflow=0, underflow=0.
REQ-018 SHALL evaluate exactly one NORM action per cycle, in this priority order:
- (a) mant=0: result=0x00000000 (+0, sign forced 0), flags 0 -> DONE.
- (b) mant[24]=1 and exp=0xFE: result={sign,8'hFF,23'b0}, overflow=1 -> DONE.
- (c) mant[24]=1, otherwise: mant>>1 (LSB truncated), exp+1, pack -> DONE.
- (d) mant[23]=1: pack {sign,exp,mant[22:0]} -> DONE.
- (e) exp<=1: pack {sign,8'h00,mant[22:0]}, underflow=1 -> DONE.
- (f) otherwise: mant<<1, exp-1, remain in NORM.
REQ-019 SHALL truncate on rounding; no rounding increment is performed.
REQ-020 SHALL use latency n+1 clk edges from the acceptance edge to the edge that sets out_valid, where n is the number of left shifts (0..23); maximum latency is 24.
REQ-021 SHALL hold result, overflow and underflow stable while out_valid=1 and out_ready=0.
REQ-022 SHALL, on an edge with out_valid=1 and out_ready=1, clear out_valid and return to IDLE; the next input is accepted no earlier than the following edge.
REQ-023 SHALL ignore in_valid outside IDLE; the upstream holds its data.
REQ-024 SHALL update overflow and underflow only when entering DONE, and SHALL clear them on leaving DONE.

Reset
REQ-025 SHALL, on an edge with rst=1, set state=IDLE, result=0, out_valid=0, overflow=0, underflow=0 and all internal registers to 0, regardless of state.
REQ-026 SHALL drive in_ready=1 in the first cycle after rst is deasserted.
REQ-027 SHALL take priority for rst over in_valid and out_ready on the same edge; a concurrent input is not captured.
REQ-028 SHALL discard any operation in progress when rst is asserted mid-NORM or mid-DONE; no out_valid follows.

Verification
REQ-029 SHALL be verified with sign=0, Ex=0x80, mant=0x0800000 -> result=0x40000000 and out_valid on the first edge after acceptance, flags 0.
REQ-030 SHALL be verified with sign=0, Ex=0x7F, mant=0x1800000 -> result=0x40400000 after 1 edge, flags 0.
REQ-031 SHALL be verified with sign=0, Ex=0x85, mant=0x0000001 -> 23 shifts, result=0x37000000, out_valid on the 24th edge after acceptance.
REQ-032 SHALL be verified with Ex=0x03, mant=0x0000100 -> 2 shifts, result=0x00000400, underflow=1.
REQ-033 SHALL be verified with sign=1, Ex=0xFE, mant=0x1000000 -> result=0xFF800000, overflow=1.
REQ-034 SHALL be verified for zero and backpressure as follows:
- sign=1, mant=0 -> result=0x00000000.
- Hold out_ready=0 for 3 cycles -> result and out_valid stable, in_ready=0.
- Then assert rst during a REQ-031 NORM sequence -> out_valid=0 and in_ready=1 after reset.
